ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter IM_WORDS, default 256: instruction-memory depth in words.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pc_wr  in  1  controller strobe: load next PC at the clock edge.
REQ-006 ir_wr  in  1  controller strobe: latch im_dout into IR at the clock edge.
REQ-007 npc_sel  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump (j/jal), 11 register (jr).
REQ-008 zero  in  1  ALU equality flag that qualifies a branch.
REQ-009 rs_data  in  32  register value used as the jr target.
REQ-010 im_dout  in  32  instruction word returned by the instruction memory.
REQ-011 im_addr  out  8  word address to the instruction memory, equal to pc[9:2].
REQ-012 pc  out  32  address of the instruction currently held.
REQ-013 pc4  out  32  pc+4, used as the jal link value.
REQ-014 ir  out  32  instruction register.
REQ-015 fetch_err  out  1  sticky flag: an illegal PC was loaded.

Function
REQ-016 im_addr SHALL be driven combinationally from pc[9:2], so the instruction memory returns its word in the same cycle.
REQ-017 pc4 SHALL equal pc+4, computed modulo 2^32.
REQ-018 npc SHALL be computed combinationally from the current pc and IR fields as follows.
  - 00: pc+4.
  - 01: if zero=1, pc+4 + (sign-extended ir[15:0] << 2); otherwise pc+4.
  - 10: {pc4[31:28], ir[25:0], 2'b00}.
  - 11: rs_data unchanged.
REQ-019 When pc_wr=1, pc SHALL load npc at the clock edge; otherwise pc holds.
REQ-020 When ir_wr=1, ir SHALL load im_dout at the clock edge; otherwise ir holds.
REQ-021 If pc_wr and ir_wr are asserted in the same cycle, both SHALL update: ir takes the word at the old pc, and npc uses the old ir.
REQ-022 A loaded PC value SHALL be illegal when its low two bits are nonzero, or when it lies outside PC_RESET .. PC_RESET+4*IM_WORDS-4.
REQ-023 fetch_err SHALL set on the edge that loads an illegal PC and SHALL stay at 1 until reset.
REQ-024 When an illegal PC is loaded, pc SHALL still take the loaded value; im_addr then wraps, since only pc[9:2] is used.
REQ-025 All additions SHALL be 32-bit and wrap silently.
REQ-026 Branch offsets SHALL be sign-extended from 16 bits before the 2-bit shift.
REQ-027 The block SHALL contain no combinational path from im_dout to npc.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL set pc=PC_RESET, ir=32'h0000_0000 and fetch_err=0, overriding pc_wr and ir_wr.
REQ-029 After reset, im_addr SHALL equal PC_RESET[9:2] and pc4 SHALL equal PC_RESET+4.
REQ-030 Reset asserted mid-instruction SHALL discard any pending npc; the next fetch SHALL start from PC_RESET.
REQ-031 A zero-valued ir after reset SHALL decode as nop (sll $0,$0,0).

Structure
REQ-032 The npc_sel encodings (NPC_PC4, NPC_BR, NPC_J, NPC_JR) and the PC_RESET value SHALL live in the shared CPU package.
REQ-033 The next-PC logic SHALL be a combinational sub-module named npc, instantiated inside ifu.
REQ-034 The pc, ir and fetch_err registers SHALL be in ifu itself.

Verification
REQ-035 Sequential fetch: reset, then 3 cycles of pc_wr=1 and ir_wr=1 with sel=00.
  - Required: pc = 3004, 3008, 300C.
  - Required: im_addr = 01, 02, 03.
REQ-036 Branch taken: pc=3010, ir[15:0]=FFFE, zero=1, sel=01, pc_wr=1.
  - Required: pc=300C.
  - Repeat with zero=0: required pc=3014.
REQ-037 Jump: pc=3000, ir=08000C10, sel=10, pc_wr=1.
  - Required: pc=00003040.
  - Required: pc4 before the edge = 3004.
REQ-038 jr misaligned: rs_data=00003002, sel=11, pc_wr=1.
  - Required: pc=3002 and fetch_err=1.
  - fetch_err stays 1 through 5 legal loads, then clears on reset.
REQ-039 Out-of-range load: rs_data=00003400 with IM_WORDS=256.
  - Required: fetch_err=1 and im_addr=00.
REQ-040 Reset mid-operation: reset=1 together with pc_wr=1 and ir_wr=1 at pc=3020.
  - Required next cycle: pc=3000, ir=0, fetch_err=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared CPU definitions: next-PC source encodings, reset constants and the
// fetch-address legality check.
package ifu_pkg;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
    localparam logic [31:0] IR_RESET_VAL = 32'h0000_0000;

    // Misaligned or outside the instruction memory window [lo, hi]
    function automatic logic pc_illegal(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection. Only the registered IR feeds this block,
// so there is no path from the instruction memory output to the next PC.
module npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] imm26,
    input  logic [1:0]  npc_sel,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc4,
    output logic [31:0] next_pc
);

    logic [31:0] br_off_s;

    assign pc4 = pc + 32'd4;

    // Next-PC mux; branch offset is sign-extended before the word shift
    always_comb begin
        br_off_s = {{14{imm26[15]}}, imm26[15:0], 2'b00};
        next_pc  = pc4;
        case (npc_sel_e'(npc_sel))
            NPC_PC4: next_pc = pc4;
            NPC_BR: begin
                if (zero) begin
                    next_pc = pc4 + br_off_s;
                end else begin
                    next_pc = pc4;
                end
            end
            NPC_J:   next_pc = {pc4[31:28], imm26, 2'b00};
            NPC_JR:  next_pc = rs_data;
            default: next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, IR and sticky fetch-error registers around the
// combinational next-PC selector.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_VAL,
    parameter int          IM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_wr,
    input  logic        ir_wr,
    input  logic [1:0]  npc_sel,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic [31:0] im_dout,
    output logic [7:0]  im_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ir,
    output logic        fetch_err
);

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic        fetch_err_r;
    logic [31:0] npc_s;

    npc u_npc (
        .pc      (pc_r),
        .imm26   (ir_r[25:0]),
        .npc_sel (npc_sel),
        .zero    (zero),
        .rs_data (rs_data),
        .pc4     (pc4),
        .next_pc (npc_s)
    );

    // PC, IR and sticky error update; reset overrides both write strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= PC_RESET;
            ir_r        <= IR_RESET_VAL;
            fetch_err_r <= 1'b0;
        end else begin
            if (pc_wr) begin
                pc_r <= npc_s;
                if (pc_illegal(npc_s, PC_RESET, PC_LAST)) begin
                    fetch_err_r <= 1'b1;
                end
            end
            if (ir_wr) begin
                ir_r <= im_dout;
            end
        end
    end

    // Only pc[9:2] addresses the memory, so out-of-window PCs wrap
    assign im_addr   = pc_r[9:2];
    assign pc        = pc_r;
    assign ir        = ir_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the fetch rules.
module tb_ifu;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_wr;
    logic        ir_wr;
    logic [1:0]  npc_sel;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] im_dout;
    logic [7:0]  im_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ir;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [256];
    logic        use_mem;
    logic [31:0] im_force;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_err;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam int          WORDS = 256;

    ifu dut (
        .clk       (clk),
        .reset     (reset),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .npc_sel   (npc_sel),
        .zero      (zero),
        .rs_data   (rs_data),
        .im_dout   (im_dout),
        .im_addr   (im_addr),
        .pc        (pc),
        .pc4       (pc4),
        .ir        (ir),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    // Instruction memory behaviour: word at the DUT's address, or a forced word
    always_comb im_dout = use_mem ? mem[im_addr] : im_force;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [1:0] sel, input logic z,
                                             input logic [31:0] rs);
        int off;
        off = $signed(m_ir[15:0]) * 4;
        case (sel)
            2'd0: return m_pc + 32'd4;
            2'd1: return z ? (m_pc + 32'd4 + 32'(off)) : (m_pc + 32'd4);
            2'd2: return ((m_pc + 32'd4) & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
            default: return rs;
        endcase
    endfunction

    function automatic logic ref_bad(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a < BASE) || (a > BASE + 32'(4 * WORDS) - 32'd4);
    endfunction

    // One clock: drive, advance the model, then compare all outputs
    task automatic step(input logic rst, input logic pw, input logic iw,
                        input logic [1:0] sel, input logic z, input logic [31:0] rs);
        logic [31:0] word;
        logic [31:0] nxt;
        @(negedge clk);
        reset = rst; pc_wr = pw; ir_wr = iw; npc_sel = sel; zero = z; rs_data = rs;
        word = use_mem ? mem[m_pc[9:2]] : im_force;
        if (rst) begin
            m_pc = BASE; m_ir = 32'd0; m_err = 1'b0;
        end else begin
            nxt = ref_next(sel, z, rs);
            if (pw) begin
                m_pc = nxt;
                if (ref_bad(nxt)) m_err = 1'b1;
            end
            if (iw) m_ir = word;
        end
        @(posedge clk);
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("ir", ir, m_ir);
        check_eq("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        check_eq("im_addr", {24'd0, im_addr}, {24'd0, m_pc[9:2]});
        check_eq("pc4", pc4, m_pc + 32'd4);
    endtask

    task automatic load_ir(input logic [31:0] w);
        use_mem = 1'b0; im_force = w;
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0);
        use_mem = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pc_wr = 1'b0; ir_wr = 1'b0; npc_sel = 2'd0; zero = 1'b0;
        rs_data = 32'd0; use_mem = 1'b1; im_force = 32'd0;
        m_pc = 32'd0; m_ir = 32'd0; m_err = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset overrides write strobes
        step(1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 32'h1234_5678);
        check_eq("rst_pc", pc, 32'h0000_3000);
        check_eq("rst_ir", ir, 32'h0000_0000);
        check_eq("rst_pc4", pc4, 32'h0000_3004);
        check_eq("rst_addr", {24'd0, im_addr}, 32'h0000_0000);

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'd0);
            check_eq("seq_pc", pc, 32'h0000_3000 + 32'(4 * i));
            check_eq("seq_addr", {24'd0, im_addr}, 32'(i));
        end

        // Branch taken and not taken with offset -2 words
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3010);
        load_ir(32'h1000_FFFE);
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'd0);
        check_eq("br_taken", pc, 32'h0000_300C);
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3010);
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'd0);
        check_eq("br_not", pc, 32'h0000_3014);

        // Jump
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3000);
        load_ir(32'h0800_0C10);
        check_eq("j_pc4", pc4, 32'h0000_3004);
        step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'd0);
        check_eq("j_pc", pc, 32'h0000_3040);

        // Misaligned jr: sticky through legal loads, cleared by reset
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3002);
        check_eq("mis_pc", pc, 32'h0000_3002);
        check_eq("mis_err", {31'd0, fetch_err}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3000 + 32'(8 * i));
            check_eq("sticky", {31'd0, fetch_err}, 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
        check_eq("err_clr", {31'd0, fetch_err}, 32'd0);

        // Out-of-range jr wraps the memory address
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3400);
        check_eq("oor_err", {31'd0, fetch_err}, 32'd1);
        check_eq("oor_addr", {24'd0, im_addr}, 32'h0000_0000);

        // Reset mid-operation
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_3020);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'd0);
        check_eq("mid_pc", pc, 32'h0000_3000);
        check_eq("mid_ir", ir, 32'h0000_0000);
        check_eq("mid_err", {31'd0, fetch_err}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? $urandom
                                             : BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            step(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom), rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
